// File: rtl/bit_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder_pkg
// Purpose  : Shared definitions for the bit-serial adder: FSM state encoding
//            and the default operand width.
// Ports    : none (package)
// Config   : BIT_SERIAL_ADDER_SUB_EN (used by bit_serial_adder, not here)
// Revision : 1.0 - initial release
// ============================================================================
package bit_serial_adder_pkg;

   localparam int c_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : bit_serial_adder_pkg
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module   : half_adder
// Purpose  : Single-bit combinational half adder.
// Ports    : a, b   - input bits
//            sum    - a XOR b
//            carry  - a AND b
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule : half_adder
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder
// Purpose  : Bit-serial WIDTH-bit adder. Resolves one bit pair per clock,
//            LSB first, using a full-adder slice built from two half_adder
//            instances and a carry OR. start/done handshake.
// Ports    : clk    - rising-edge clock
//            rst    - synchronous active-high reset
//            start  - request pulse, accepted only while busy=0
//            A, B   - operands, sampled on the accepting edge
//            op_sub - (BIT_SERIAL_ADDER_SUB_EN only) 1 selects A-B
//            busy   - high while bits are being processed
//            done   - one-cycle pulse when sum/carry become valid
//            sum    - result word, held until next result is published
//            carry  - carry-out of the MSB (for subtract: 1 = no borrow)
// Config   : BIT_SERIAL_ADDER_SUB_EN - adds op_sub port and subtraction
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = c_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef BIT_SERIAL_ADDER_SUB_EN
   input  logic             op_sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int c_CNT_W = $clog2(WIDTH) + 1;
   localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_res;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_c;

   logic w_s1, w_c1, w_s2, w_c2, w_cout;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_init;
   logic [WIDTH-1:0] w_res_next;

   // Subtraction is A + ~B + 1: invert B at load and seed the carry.
`ifdef BIT_SERIAL_ADDER_SUB_EN
   assign w_b_load = op_sub ? ~B : B;
   assign w_c_init = op_sub;
`else
   assign w_b_load = B;
   assign w_c_init = 1'b0;
`endif

   // Full-adder slice on bit 0 of the operand shift registers.
   half_adder u_ha1 (.a(r_a[0]), .b(r_b[0]), .sum(w_s1), .carry(w_c1));
   half_adder u_ha2 (.a(w_s1),   .b(r_c),    .sum(w_s2), .carry(w_c2));
   assign w_cout = w_c1 | w_c2;

   // Slice sum enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
   assign w_res_next = {w_s2, r_res[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_c     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         carry   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               // DONE behaves like IDLE for start so adds can run back to back.
               done <= 1'b0;
               if (start) begin
                  r_a     <= A;
                  r_b     <= w_b_load;
                  r_c     <= w_c_init;
                  r_cnt   <= '0;
                  r_res   <= '0;
                  busy    <= 1'b1;
                  r_state <= ADD;
               end else begin
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            ADD: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_c   <= w_cout;
               r_res <= w_res_next;
               r_cnt <= r_cnt + c_CNT_W'(1);
               if (r_cnt == c_TERM) begin
                  // Publish directly from the slice so sum never shows
                  // partial shift contents.
                  sum     <= w_res_next;
                  carry   <= w_cout;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= DONE;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : bit_serial_adder
`default_nettype wire
